// File: rtl/soc_uart_rx_if.sv
// Data-side device bus (port B) as seen by soc_uart_rx.
// The CPU/bus fabric is the master; the UART receiver is the slave.
interface soc_uart_rx_if;
    logic [31:0] addr_b;
    logic [31:0] data_b_in;
    logic        data_b_we;
    logic [31:0] data_b;
    logic        strobe_b;

    modport master (
        output addr_b,
        output data_b_in,
        output data_b_we,
        input  data_b,
        input  strobe_b
    );

    modport slave (
        input  addr_b,
        input  data_b_in,
        input  data_b_we,
        output data_b,
        output strobe_b
    );
endinterface

// File: rtl/soc_uart_rx.sv
// Memory-mapped UART receiver: 8N1 deserialiser feeding a byte FIFO on bus port B.
// Define SOC_UART_RX_PARITY_EN for 8E1 frames with a sticky parity-error flag.
module soc_uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_AW      = 4,
    parameter logic [31:0] ADDR_STATUS  = 32'd65537,
    parameter logic [31:0] ADDR_DATA    = 32'd65539
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rx,
    soc_uart_rx_if.slave bus,
    output logic         irq_rx
);
    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned CW    = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [FIFO_AW:0] CNT_FULL = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef SOC_UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_e;

    logic         rx_meta_q;
    logic         rx_s_q;
    state_e       state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]   idx_q, idx_d;
    logic [7:0]   shift_q, shift_d;
    logic         expire;
    logic         push_req;
    logic         set_frame;
    logic         set_par;

    logic [7:0]         fifo_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q;
    logic [FIFO_AW-1:0] rd_ptr_q;
    logic [FIFO_AW:0]   count_q;
    logic               empty;
    logic               full;
    logic               push_ok;
    logic               pop;
    logic               hit_status;
    logic               hit_data;
    logic               rd_match;
    logic               prev_match_q;
    logic               clr_wr;

    logic ovf_q, ovf_d;
    logic frame_q, frame_d;
    logic par_err;
    logic [31:0] status_w;
    logic unused_bits;

    // Two-flop synchroniser; rx is asynchronous to clk.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

`ifdef SOC_UART_RX_PARITY_EN
    logic par_bad_q, par_bad_d;
    logic par_q, par_d;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
`ifdef SOC_UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
`ifdef SOC_UART_RX_PARITY_EN
            par_bad_q <= par_bad_d;
`endif
        end
    end

    assign expire = (cnt_q == '0);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        push_req  = 1'b0;
        set_frame = 1'b0;
        set_par   = 1'b0;
`ifdef SOC_UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
`endif
        if (state_q != S_IDLE && state_q != S_BREAK && !expire) begin
            cnt_d = cnt_q - 1'b1;
        end
        unique case (state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    state_d = S_START;
                    cnt_d   = HALF_M1;
`ifdef SOC_UART_RX_PARITY_EN
                    par_bad_d = 1'b0;
`endif
                end
            end
            S_START: begin
                if (expire) begin
                    if (!rx_s_q) begin
                        state_d = S_DATA;
                        idx_d   = 3'd0;
                        cnt_d   = FULL_M1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (expire) begin
                    shift_d[idx_q] = rx_s_q;
                    idx_d          = idx_q + 3'd1;
                    cnt_d          = FULL_M1;
                    if (idx_q == 3'd7) begin
`ifdef SOC_UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef SOC_UART_RX_PARITY_EN
            S_PARITY: begin
                if (expire) begin
                    state_d = S_STOP;
                    cnt_d   = FULL_M1;
                    if (^{shift_q, rx_s_q}) begin
                        par_bad_d = 1'b1;
                        set_par   = 1'b1;
                    end
                end
            end
`endif
            S_STOP: begin
                if (expire) begin
                    if (rx_s_q) begin
`ifdef SOC_UART_RX_PARITY_EN
                        push_req = !par_bad_q;
`else
                        push_req = 1'b1;
`endif
                        state_d = S_IDLE;
                    end else begin
                        set_frame = 1'b1;
                        state_d   = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign hit_status = (bus.addr_b == ADDR_STATUS);
    assign hit_data   = (bus.addr_b == ADDR_DATA);
    assign rd_match   = hit_data && !bus.data_b_we;
    assign clr_wr     = hit_status && bus.data_b_we;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_FULL);
    // A held address pops only on the first cycle of the access.
    assign pop     = rd_match && !prev_match_q && !empty;
    assign push_ok = push_req && (!full || pop);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_q[wr_ptr_q] <= shift_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            prev_match_q <= 1'b0;
        end else begin
            prev_match_q <= rd_match;
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push_ok && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push_ok) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // Sticky flags: write-1-to-clear, a same-cycle set takes priority.
    assign ovf_d   = (push_req && full && !pop)
                   || (ovf_q && !(clr_wr && bus.data_b_in[1]));
    assign frame_d = set_frame
                   || (frame_q && !(clr_wr && bus.data_b_in[2]));

`ifdef SOC_UART_RX_PARITY_EN
    assign par_d   = set_par
                   || (par_q && !(clr_wr && bus.data_b_in[3]));
    assign par_err = par_q;
    assign unused_bits = ^{bus.data_b_in[31:4], bus.data_b_in[0]};
`else
    assign par_err = 1'b0;
    assign unused_bits = ^{bus.data_b_in[31:3], bus.data_b_in[0], set_par};
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q   <= 1'b0;
            frame_q <= 1'b0;
`ifdef SOC_UART_RX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            ovf_q   <= ovf_d;
            frame_q <= frame_d;
`ifdef SOC_UART_RX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign status_w = {16'b0, 8'(count_q), 4'b0,
                       par_err, frame_q, ovf_q, !empty};

    always_comb begin
        bus.data_b = 32'h0;
        if (rst) begin
            if (hit_status) begin
                bus.data_b = status_w;
            end else if (hit_data && !empty) begin
                bus.data_b = {24'b0, fifo_q[rd_ptr_q]};
            end
        end
    end

    assign bus.strobe_b = rst && (hit_status || hit_data);
    assign irq_rx       = rst && !empty;
endmodule

// File: tb/tb_soc_uart_rx.sv
// Scoreboard bench for soc_uart_rx at CLKS_PER_BIT=16, FIFO_AW=2.
// Accepted bytes are queued when sent and popped when read back over the bus.
module tb_soc_uart_rx;
    localparam int CPB = 16;
    localparam int AW  = 2;
    localparam logic [31:0] A_ST = 32'd65537;
    localparam logic [31:0] A_DT = 32'd65539;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rx  = 1'b1;
    logic irq_rx;
    logic unused_par;

    soc_uart_rx_if bus ();

    soc_uart_rx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_AW(AW),
        .ADDR_STATUS(A_ST),
        .ADDR_DATA(A_DT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx(rx),
        .bus(bus),
        .irq_rx(irq_rx)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] exp_q[$];

    task automatic bus_rd(input logic [31:0] a,
                          output logic [31:0] d, output logic s);
        @(negedge clk);
        bus.addr_b    = a;
        bus.data_b_we = 1'b0;
        #1;
        d = bus.data_b;
        s = bus.strobe_b;
        @(negedge clk);
        bus.addr_b = 32'h0;
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] v);
        @(negedge clk);
        bus.addr_b    = a;
        bus.data_b_in = v;
        bus.data_b_we = 1'b1;
        @(negedge clk);
        bus.addr_b    = 32'h0;
        bus.data_b_in = 32'h0;
        bus.data_b_we = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop,
                              input logic par);
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
`ifdef SOC_UART_RX_PARITY_EN
        rx = par;
        repeat (CPB) @(negedge clk);
`else
        unused_par = par;
`endif
        rx = stop;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic s;
        rst = 1'b0;
        bus.addr_b    = A_ST;
        bus.data_b_in = 32'h0;
        bus.data_b_we = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        vectors++;
        if (bus.strobe_b !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_strobe got %0b exp 0", bus.strobe_b);
        end
        vectors++;
        if (bus.data_b !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_data got %h exp 0", bus.data_b);
        end
        vectors++;
        if (irq_rx !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_irq got %0b exp 0", irq_rx);
        end
        @(negedge clk);
        rst = 1'b1;
        bus.addr_b = 32'h0;
        bus_rd(A_ST, d, s);
        vectors++;
        if (d !== 32'h0 || s !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_status got %h/%0b exp 0/1", d, s);
        end
    endtask

    task automatic test_single();
        logic [31:0] d;
        logic s;
        logic [7:0] e;
        send_frame(8'h41, 1'b1, ^8'h41);
        exp_q.push_back(8'h41);
        bus_rd(A_ST, d, s);
        vectors++;
        if (d !== 32'h0000_0101) begin
            miscompares++;
            $display("FAIL single_status got %h exp 00000101", d);
        end
        vectors++;
        if (irq_rx !== 1'b1) begin
            miscompares++;
            $display("FAIL single_irq got %0b exp 1", irq_rx);
        end
        bus_wr(A_DT, 32'hFF);
        bus_rd(A_ST, d, s);
        vectors++;
        if (d !== 32'h0000_0101) begin
            miscompares++;
            $display("FAIL data_write_ignored got %h exp 00000101", d);
        end
        bus_rd(A_DT, d, s);
        e = exp_q.pop_front();
        vectors++;
        if (d !== {24'h0, e} || s !== 1'b1) begin
            miscompares++;
            $display("FAIL single_data got %h/%0b exp %h/1", d, s, e);
        end
        bus_rd(A_ST, d, s);
        vectors++;
        if (d !== 32'h0 || irq_rx !== 1'b0) begin
            miscompares++;
            $display("FAIL single_empty got %h/%0b exp 0/0", d, irq_rx);
        end
    endtask

    task automatic test_hold();
        logic [31:0] d;
        logic s;
        logic [7:0] e;
        send_frame(8'h11, 1'b1, ^8'h11);
        exp_q.push_back(8'h11);
        send_frame(8'h22, 1'b1, ^8'h22);
        exp_q.push_back(8'h22);
        @(negedge clk);
        bus.addr_b    = A_DT;
        bus.data_b_we = 1'b0;
        #1;
        e = exp_q.pop_front();
        vectors++;
        if (bus.data_b !== {24'h0, e}) begin
            miscompares++;
            $display("FAIL hold_first got %h exp %h", bus.data_b, e);
        end
        repeat (5) @(negedge clk);
        bus.addr_b = 32'h0;
        bus_rd(A_ST, d, s);
        vectors++;
        if (d !== 32'h0000_0101) begin
            miscompares++;
            $display("FAIL hold_single_pop got %h exp 00000101", d);
        end
        bus_rd(A_DT, d, s);
        e = exp_q.pop_front();
        vectors++;
        if (d !== {24'h0, e}) begin
            miscompares++;
            $display("FAIL hold_second got %h exp %h", d, e);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        logic s;
        logic [7:0] e;
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 1'b1, ^8'(i));
            if (i <= 4) exp_q.push_back(8'(i));
        end
        bus_rd(A_ST, d, s);
        vectors++;
        if (d !== 32'h0000_0403) begin
            miscompares++;
            $display("FAIL ovf_status got %h exp 00000403", d);
        end
        for (int i = 0; i < 4; i++) begin
            bus_rd(A_DT, d, s);
            e = exp_q.pop_front();
            vectors++;
            if (d !== {24'h0, e}) begin
                miscompares++;
                $display("FAIL ovf_data[%0d] got %h exp %h", i, d, e);
            end
        end
        bus_rd(A_DT, d, s);
        vectors++;
        if (d !== 32'h0) begin
            miscompares++;
            $display("FAIL empty_read got %h exp 0", d);
        end
        bus_rd(A_ST, d, s);
        vectors++;
        if (d !== 32'h0000_0002) begin
            miscompares++;
            $display("FAIL ovf_sticky got %h exp 00000002", d);
        end
        bus_wr(A_ST, 32'h2);
        bus_rd(A_ST, d, s);
        vectors++;
        if (d !== 32'h0) begin
            miscompares++;
            $display("FAIL ovf_clear got %h exp 0", d);
        end
    endtask

    task automatic test_glitch();
        logic [31:0] d;
        logic s;
        @(negedge clk);
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        bus_rd(A_ST, d, s);
        vectors++;
        if (d !== 32'h0) begin
            miscompares++;
            $display("FAIL glitch_status got %h exp 0", d);
        end
    endtask

    task automatic test_break();
        logic [31:0] d;
        logic s;
        logic [7:0] e;
        send_frame(8'h55, 1'b0, ^8'h55);
        repeat (3 * CPB) @(negedge clk);
        bus_rd(A_ST, d, s);
        vectors++;
        if (d !== 32'h0000_0004) begin
            miscompares++;
            $display("FAIL break_status got %h exp 00000004", d);
        end
        rx = 1'b1;
        repeat (4) @(negedge clk);
        send_frame(8'h66, 1'b1, ^8'h66);
        exp_q.push_back(8'h66);
        bus_rd(A_ST, d, s);
        vectors++;
        if (d !== 32'h0000_0105) begin
            miscompares++;
            $display("FAIL after_break_status got %h exp 00000105", d);
        end
        bus_rd(A_DT, d, s);
        e = exp_q.pop_front();
        vectors++;
        if (d !== {24'h0, e}) begin
            miscompares++;
            $display("FAIL after_break_data got %h exp %h", d, e);
        end
        bus_wr(A_ST, 32'h4);
        bus_rd(A_ST, d, s);
        vectors++;
        if (d !== 32'h0) begin
            miscompares++;
            $display("FAIL frame_clear got %h exp 0", d);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        logic s;
        logic [7:0] e;
        logic [7:0] b;
        b = 8'hA5;
        send_frame(8'h77, 1'b1, ^8'h77);
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = b[3];
        repeat (CPB / 2) @(negedge clk);
        rst = 1'b0;
        bus.addr_b = A_ST;
        #1;
        vectors++;
        if (bus.strobe_b !== 1'b0 || bus.data_b !== 32'h0
            || irq_rx !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_outputs got %0b/%h/%0b exp 0/0/0",
                     bus.strobe_b, bus.data_b, irq_rx);
        end
        @(negedge clk);
        rx = 1'b1;
        bus.addr_b = 32'h0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        bus_rd(A_ST, d, s);
        vectors++;
        if (d !== 32'h0) begin
            miscompares++;
            $display("FAIL midrst_status got %h exp 0", d);
        end
        send_frame(8'h5A, 1'b1, ^8'h5A);
        exp_q.push_back(8'h5A);
        bus_rd(A_DT, d, s);
        e = exp_q.pop_front();
        vectors++;
        if (d !== {24'h0, e}) begin
            miscompares++;
            $display("FAIL midrst_data got %h exp %h", d, e);
        end
    endtask

`ifdef SOC_UART_RX_PARITY_EN
    task automatic test_parity();
        logic [31:0] d;
        logic s;
        logic [7:0] e;
        send_frame(8'h03, 1'b1, 1'b1);
        bus_rd(A_ST, d, s);
        vectors++;
        if (d !== 32'h0000_0008) begin
            miscompares++;
            $display("FAIL parity_bad got %h exp 00000008", d);
        end
        send_frame(8'h03, 1'b1, 1'b0);
        exp_q.push_back(8'h03);
        bus_rd(A_ST, d, s);
        vectors++;
        if (d !== 32'h0000_0109) begin
            miscompares++;
            $display("FAIL parity_good got %h exp 00000109", d);
        end
        bus_rd(A_DT, d, s);
        e = exp_q.pop_front();
        vectors++;
        if (d !== {24'h0, e}) begin
            miscompares++;
            $display("FAIL parity_data got %h exp %h", d, e);
        end
        bus_wr(A_ST, 32'h8);
        bus_rd(A_ST, d, s);
        vectors++;
        if (d !== 32'h0) begin
            miscompares++;
            $display("FAIL parity_clear got %h exp 0", d);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_hold();
        test_overflow();
        test_glitch();
        test_break();
        test_reset_mid();
`ifdef SOC_UART_RX_PARITY_EN
        test_parity();
`endif
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_left got %0d exp 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
